// File: rtl/exec_md_stage_if.sv
// Execute-stage bus: D/E register fields in, E/M register fields and md_busy out.
interface exec_md_stage_if;
    logic [31:0] Instr_E;
    logic [31:0] PC_plus_8_E;
    logic [31:0] RS_E;
    logic [31:0] RT_E;
    logic [31:0] ext_E;
    logic [4:0]  A3_E;
    logic [4:0]  T_new_E;
    logic [31:0] Instr_M;
    logic [31:0] PC_plus_8_M;
    logic [31:0] ALU_out_M;
    logic [31:0] WriteData_M;
    logic [4:0]  A3_M;
    logic [4:0]  T_new_M;
    logic        md_busy;

    modport master (
        output Instr_E, PC_plus_8_E, RS_E, RT_E, ext_E, A3_E, T_new_E,
        input  Instr_M, PC_plus_8_M, ALU_out_M, WriteData_M, A3_M, T_new_M, md_busy
    );

    modport slave (
        input  Instr_E, PC_plus_8_E, RS_E, RT_E, ext_E, A3_E, T_new_E,
        output Instr_M, PC_plus_8_M, ALU_out_M, WriteData_M, A3_M, T_new_M, md_busy
    );
endinterface

// File: rtl/exec_md_stage.sv
// Execute stage: ALU/link/HI-LO result mux, multi-cycle mult/div unit owning HI/LO,
// and the E/M pipeline register.
module exec_md_stage #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    exec_md_stage_if.slave bus
);
    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [4:0]  NO_WRITE = 5'h1F;

    typedef enum logic {IDLE, RUN} md_state_e;

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi, lo, op_a, op_b;
    logic [1:0]       md_op;   // funct[1:0]: 00 mult, 01 multu, 10 div, 11 divu

    logic [5:0]  opcode, funct;
    logic        is_special, is_md_c, busy_c, start_c, mthi_c, mtlo_c;
    logic [31:0] result_c;
    logic [4:0]  t_new_c;
    logic [63:0] a64_c, b64_c, prod_c;
    logic [31:0] quot_c, rem_c;
    logic        sx_c;

    assign opcode     = bus.Instr_E[31:26];
    assign funct      = bus.Instr_E[5:0];
    assign is_special = (opcode == 6'h00);
    assign is_md_c    = is_special && (funct[5:2] == 4'b0110);
    assign mthi_c     = is_special && (funct == 6'h11);
    assign mtlo_c     = is_special && (funct == 6'h13);
    assign busy_c     = (state == RUN);
    assign start_c    = is_md_c && !busy_c;
    assign bus.md_busy = start_c | busy_c;

    // Result mux for the E-stage instruction.
    always_comb begin
        result_c = '0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h21:   result_c = bus.RS_E + bus.RT_E;
                    6'h23:   result_c = bus.RS_E - bus.RT_E;
                    6'h10:   result_c = hi;
                    6'h12:   result_c = lo;
                    default: result_c = '0;
                endcase
            end
            6'h0D:          result_c = bus.RS_E | bus.ext_E;
            6'h0F:          result_c = {bus.ext_E[15:0], 16'h0000};
            6'h23, 6'h2B:   result_c = bus.RS_E + bus.ext_E;
            6'h03, 6'h18:   result_c = bus.PC_plus_8_E;
            default:        result_c = '0;
        endcase
    end

    always_comb begin
        t_new_c = bus.T_new_E - 5'd1;
        if (bus.T_new_E == NO_WRITE) t_new_c = NO_WRITE;
        else if (bus.T_new_E == 5'd0) t_new_c = 5'd0;
    end

    // Multiply via explicit sign/zero extension; divide guarded against zero divisor.
    always_comb begin
        sx_c   = ~md_op[0];
        a64_c  = {{32{sx_c & op_a[31]}}, op_a};
        b64_c  = {{32{sx_c & op_b[31]}}, op_b};
        prod_c = a64_c * b64_c;
        quot_c = '0;
        rem_c  = '0;
        if (op_b != 32'd0) begin
            if (md_op[0]) begin
                quot_c = op_a / op_b;
                rem_c  = op_a % op_b;
            end else begin
                quot_c = $unsigned($signed(op_a) / $signed(op_b));
                rem_c  = $unsigned($signed(op_a) % $signed(op_b));
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.Instr_M     <= '0;
            bus.PC_plus_8_M <= '0;
            bus.ALU_out_M   <= '0;
            bus.WriteData_M <= '0;
            bus.A3_M        <= '0;
            bus.T_new_M     <= NO_WRITE;
            state           <= IDLE;
            cnt             <= '0;
            hi              <= '0;
            lo              <= '0;
            op_a            <= '0;
            op_b            <= '0;
            md_op           <= '0;
        end else begin
            bus.Instr_M     <= bus.Instr_E;
            bus.PC_plus_8_M <= bus.PC_plus_8_E;
            bus.ALU_out_M   <= result_c;
            bus.WriteData_M <= bus.RT_E;
            bus.A3_M        <= bus.A3_E;
            bus.T_new_M     <= t_new_c;
            if (mthi_c) hi <= bus.RS_E;
            if (mtlo_c) lo <= bus.RS_E;
            // Completion write is placed after mthi/mtlo so it wins on a shared edge.
            case (state)
                IDLE: begin
                    if (start_c) begin
                        state <= RUN;
                        op_a  <= bus.RS_E;
                        op_b  <= bus.RT_E;
                        md_op <= funct[1:0];
                        cnt   <= funct[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        if (!md_op[1]) begin
                            hi <= prod_c[63:32];
                            lo <= prod_c[31:0];
                        end else if (op_b != 32'd0) begin
                            hi <= rem_c;
                            lo <= quot_c;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_md_stage.sv
// Directed self-checking bench for exec_md_stage.
module tb_exec_md_stage;
    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] ADDU  = 32'h0000_0021;
    localparam logic [31:0] SUBU  = 32'h0000_0023;
    localparam logic [31:0] ORI   = 32'h3400_0000;
    localparam logic [31:0] LUI   = 32'h3C00_0000;
    localparam logic [31:0] SW    = 32'hAC00_0000;
    localparam logic [31:0] JAL   = 32'h0C00_0000;
    localparam logic [31:0] BEQ   = 32'h1000_0000;
    localparam logic [31:0] MFHI  = 32'h0000_0010;
    localparam logic [31:0] MTHI  = 32'h0000_0011;
    localparam logic [31:0] MFLO  = 32'h0000_0012;
    localparam logic [31:0] MTLO  = 32'h0000_0013;
    localparam logic [31:0] MULT  = 32'h0000_0018;
    localparam logic [31:0] MULTU = 32'h0000_0019;
    localparam logic [31:0] DIV   = 32'h0000_001A;
    localparam logic [31:0] DIVU  = 32'h0000_001B;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    exec_md_stage_if bus ();

    exec_md_stage #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] ext, input logic [4:0] tn);
        bus.Instr_E     = ins;
        bus.RS_E        = rs;
        bus.RT_E        = rt;
        bus.ext_E       = ext;
        bus.T_new_E     = tn;
        bus.A3_E        = 5'd3;
        bus.PC_plus_8_E = 32'h0000_1008;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue an MD op, then nops; return the number of cycles md_busy stayed high.
    task automatic md_run(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                          input int exp_cyc, input string tag);
        int n;
        n = 0;
        put(ins, rs, rt, 32'h0, 5'h1F);
        #1;
        while (bus.md_busy && n < 40) begin
            n++;
            tick();
            put(NOP, 32'h0, 32'h0, 32'h0, 5'h1F);
            #1;
        end
        chk(tag, 32'(n), 32'(exp_cyc));
    endtask

    task automatic read_hilo(input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
        put(MFHI, 32'h0, 32'h0, 32'h0, 5'h1F);
        tick();
        chk({tag, "_hi"}, bus.ALU_out_M, exp_hi);
        put(MFLO, 32'h0, 32'h0, 32'h0, 5'h1F);
        tick();
        chk({tag, "_lo"}, bus.ALU_out_M, exp_lo);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        put(NOP, 32'h0, 32'h0, 32'h0, 5'h1F);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_alu", bus.ALU_out_M, 32'h0);
        chk("rst_tnew", 32'(bus.T_new_M), 32'h1F);
        chk("rst_busy", 32'(bus.md_busy), 32'h0);
        read_hilo(32'h0, 32'h0, "rst");

        // ALU paths
        put(ADDU, 32'hFFFF_FFFF, 32'h2, 32'h0, 5'd2);
        tick();
        chk("addu", bus.ALU_out_M, 32'h1);
        chk("addu_tnew", 32'(bus.T_new_M), 32'd1);
        chk("addu_wd", bus.WriteData_M, 32'h2);
        chk("addu_a3", 32'(bus.A3_M), 32'd3);
        chk("addu_instr", bus.Instr_M, ADDU);
        put(SUBU, 32'h0, 32'h1, 32'h0, 5'd1);
        tick();
        chk("subu", bus.ALU_out_M, 32'hFFFF_FFFF);
        put(LUI, 32'h0, 32'h0, 32'h0000_1234, 5'd1);
        tick();
        chk("lui", bus.ALU_out_M, 32'h1234_0000);
        put(ORI, 32'h0000_00F0, 32'h0, 32'h0000_000F, 5'd1);
        tick();
        chk("ori", bus.ALU_out_M, 32'h0000_00FF);
        chk("ori_tnew", 32'(bus.T_new_M), 32'd0);
        put(SW, 32'h0000_0100, 32'hDEAD_BEEF, 32'h4, 5'h1F);
        tick();
        chk("sw_addr", bus.ALU_out_M, 32'h0000_0104);
        chk("sw_tnew", 32'(bus.T_new_M), 32'h1F);
        chk("sw_wd", bus.WriteData_M, 32'hDEAD_BEEF);
        put(JAL, 32'h5, 32'h6, 32'h7, 5'd0);
        tick();
        chk("jal", bus.ALU_out_M, 32'h0000_1008);
        chk("jal_pc", bus.PC_plus_8_M, 32'h0000_1008);
        chk("tnew_zero", 32'(bus.T_new_M), 32'd0);
        put(BEQ, 32'h5, 32'h6, 32'h7, 5'd4);
        tick();
        chk("other_zero", bus.ALU_out_M, 32'h0);
        chk("tnew_dec", 32'(bus.T_new_M), 32'd3);

        // Multiply
        md_run(MULT, 32'hFFFF_FFFE, 32'h3, 6, "mult_busy");
        read_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
        md_run(MULTU, 32'hFFFF_FFFE, 32'h3, 6, "multu_busy");
        read_hilo(32'h0000_0002, 32'hFFFF_FFFA, "multu");

        // Divide
        md_run(DIV, 32'hFFFF_FFF9, 32'h2, 11, "div_busy");
        read_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        md_run(DIV, 32'h0000_0007, 32'hFFFF_FFFE, 11, "div2_busy");
        read_hilo(32'h0000_0001, 32'hFFFF_FFFD, "div2");
        md_run(DIVU, 32'h0000_1234, 32'h0, 11, "divz_busy");
        read_hilo(32'h0000_0001, 32'hFFFF_FFFD, "divz");

        // mthi during RUN, then completion overwrites
        put(MULTU, 32'h5, 32'h5, 32'h0, 5'h1F);
        tick();
        put(MTHI, 32'h0000_00AA, 32'h0, 32'h0, 5'h1F);
        tick();
        put(MFHI, 32'h0, 32'h0, 32'h0, 5'h1F);
        tick();
        chk("mthi_run", bus.ALU_out_M, 32'h0000_00AA);
        put(NOP, 32'h0, 32'h0, 32'h0, 5'h1F);
        n = 0;
        #1;
        while (bus.md_busy && n < 40) begin
            n++;
            tick();
        end
        chk("mthi_wait", 32'(n), 32'd3);
        read_hilo(32'h0, 32'h0000_0019, "mthi_done");

        // mtlo on the completion edge loses
        put(MULTU, 32'h6, 32'h7, 32'h0, 5'h1F);
        tick();
        repeat (4) begin
            put(NOP, 32'h0, 32'h0, 32'h0, 5'h1F);
            tick();
        end
        put(MTLO, 32'h0000_0055, 32'h0, 32'h0, 5'h1F);
        tick();
        #1;
        chk("mtlo_edge_busy", 32'(bus.md_busy), 32'h0);
        read_hilo(32'h0, 32'h0000_002A, "mtlo_edge");

        // Back-to-back mult at t+6
        put(MULT, 32'h2, 32'h3, 32'h0, 5'h1F);
        n = 0;
        #1;
        while (bus.md_busy && n < 40) begin
            n++;
            tick();
            if (n == 6) put(MULT, 32'h4, 32'hFFFF_FFFB, 32'h0, 5'h1F);
            else        put(NOP, 32'h0, 32'h0, 32'h0, 5'h1F);
            #1;
        end
        chk("b2b_busy", 32'(n), 32'd12);
        read_hilo(32'hFFFF_FFFF, 32'hFFFF_FFEC, "b2b");

        // Reset pulse at cycle 3 of a div aborts it
        put(DIV, 32'd100, 32'd7, 32'h0, 5'h1F);
        tick();
        put(NOP, 32'h0, 32'h0, 32'h0, 5'h1F);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.md_busy), 32'h0);
        chk("abort_tnew", 32'(bus.T_new_M), 32'h1F);
        repeat (2) tick();
        reset = 1'b1;
        repeat (12) tick();
        #1;
        chk("abort_idle", 32'(bus.md_busy), 32'h0);
        read_hilo(32'h0, 32'h0, "abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
